fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of producers sharing one sync FIFO write port (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of one write word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-producer write request; held until matching gnt.
REQ-006 SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  producer i data in bits [i*DATA_WIDTH +: DATA_WIDTH]; stable while req[i]=1.
REQ-007 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-008 SHALL have port fifo_wr_ack  input  1  FIFO registered write acknowledge.
REQ-009 SHALL have port fifo_overflow  input  1  FIFO registered overflow flag.
REQ-010 SHALL have port fifo_wr_en  output  1  registered write enable to FIFO.
REQ-011 SHALL have port fifo_data_in  output  DATA_WIDTH  registered write data to FIFO.
REQ-012 SHALL have port gnt  output  NUM_REQ  one-hot, one-cycle pulse: producer's word accepted.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port retry_cnt  output  8  count of unacknowledged write attempts.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, CHECK.
REQ-016 IDLE: if (req & ~gnt) != 0 and fifo_full=0, SHALL select winner round-robin, searching from last_idx+1 modulo NUM_REQ, latch index, register fifo_wr_en=1 and fifo_data_in=req_data[winner], go ISSUE; otherwise stay IDLE with fifo_wr_en=0.
REQ-017 SHALL ignore req[i] in any cycle where gnt[i]=1, so a producer dropping req one cycle after gnt is never granted twice.
REQ-018 ISSUE: SHALL hold fifo_wr_en=1 for exactly one cycle, then clear it and go CHECK.
REQ-019 CHECK: fifo_wr_ack=1 SHALL pulse gnt[idx] for one cycle, update last_idx=idx, and go IDLE.
REQ-020 CHECK: fifo_wr_ack=0 (including fifo_overflow=1) SHALL raise no gnt, leave last_idx unchanged, and go IDLE, so the same producer wins the retry if still requesting.
REQ-021 Latency: req sampled in IDLE -> fifo_wr_en high next cycle -> gnt pulse 3 cycles after the req sample edge; peak throughput 1 word per 3 cycles.
REQ-022 fifo_full rising during ISSUE SHALL NOT cancel the issued write; the outcome is decided in CHECK by fifo_wr_ack.
REQ-023 fifo_data_in SHALL hold its last value when fifo_wr_en=0.
REQ-024 gnt SHALL never have more than one bit set.

Reset
REQ-025 rst=1 SHALL asynchronously force: state=IDLE, fifo_wr_en=0, fifo_data_in=0, gnt=0, busy=0, retry_cnt=0, last_idx=NUM_REQ-1.
REQ-026 rst asserted mid-operation SHALL abandon any in-flight write, with no gnt issued for it.

Configuration
REQ-027 With macro FIFO_ARB_RETRY_CNT_EN defined: retry_cnt SHALL increment by 1 on each CHECK with fifo_wr_ack=0, saturating at 255.
REQ-028 Without FIFO_ARB_RETRY_CNT_EN: retry_cnt SHALL be constant 0, no counter logic is built, and all other behaviour is identical.

Verification
REQ-029 rst=1 with req=4'hF -> fifo_wr_en=0, gnt=0, busy=0, retry_cnt=0 immediately and throughout.
REQ-030 After reset, req=4'b0100, data2=16'hA5A5, fifo acks -> fifo_wr_en=1 with fifo_data_in=16'hA5A5 one cycle after req sample; gnt=4'b0100 two cycles later.
REQ-031 req=4'hF held, each producer drops req after its gnt and re-raises it -> gnt sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
REQ-032 fifo_full=1 for 10 cycles with req=4'b0001 -> fifo_wr_en stays 0 and busy=0; fifo_full=0 -> write issued next cycle.
REQ-033 fifo_wr_ack held 0 for the first attempt of req=4'b0010, with macro defined -> no gnt, retry_cnt=1, second write from producer 1 acked -> gnt=4'b0010.
REQ-034 rst pulsed while in ISSUE -> fifo_wr_en drops without waiting for a clock, no gnt, next grant starts search at producer 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one sync FIFO write port; optional retry counter under FIFO_ARB_RETRY_CNT_EN
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    input  logic                          fifo_wr_ack,
    input  logic                          fifo_overflow,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic [7:0]                    retry_cnt
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [IDX_W-1:0]        last_idx, last_idx_nxt;
    logic [IDX_W-1:0]        rr_winner, cand;
    logic                    rr_found;
    logic [NUM_REQ-1:0]      eligible;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic                    write_ok;
    logic                    fifo_wr_en_nxt;
    logic [DATA_WIDTH-1:0]   fifo_data_nxt;
    logic [NUM_REQ-1:0]      gnt_nxt;

    // A producer still holding req in the cycle its gnt is shown must not win again
    assign eligible = req & ~gnt;
    // An ack that coincides with overflow is not trusted as a successful write
    assign write_ok = fifo_wr_ack & ~fifo_overflow;
    assign busy     = (state != IDLE);

    // Round-robin search starting just after the last granted producer, plus its data mux
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = last_idx;
        cand      = '0;
        sel_data  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (!rr_found && eligible[cand]) begin
                rr_found  = 1'b1;
                rr_winner = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_winner == IDX_W'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: issue one write, then spend a cycle reading its ack
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rr_found && !fifo_full) state_nxt = ISSUE;
            ISSUE:   state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: next values for the registered FIFO write port, grant and pointers
    always_comb begin
        fifo_wr_en_nxt = 1'b0;
        fifo_data_nxt  = fifo_data_in;
        gnt_nxt        = '0;
        idx_nxt        = idx;
        last_idx_nxt   = last_idx;
        case (state)
            IDLE: begin
                if (rr_found && !fifo_full) begin
                    fifo_wr_en_nxt = 1'b1;
                    fifo_data_nxt  = sel_data;
                    idx_nxt        = rr_winner;
                end
            end
            CHECK: begin
                if (write_ok) begin
                    gnt_nxt[idx] = 1'b1;
                    last_idx_nxt = idx;
                end
            end
            default: ;
        endcase
    end

    // Output and pointer registers; reset parks last_idx so the first search begins at producer 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            gnt          <= '0;
            idx          <= '0;
            last_idx     <= IDX_W'(NUM_REQ - 1);
        end else begin
            fifo_wr_en   <= fifo_wr_en_nxt;
            fifo_data_in <= fifo_data_nxt;
            gnt          <= gnt_nxt;
            idx          <= idx_nxt;
            last_idx     <= last_idx_nxt;
        end
    end

`ifdef FIFO_ARB_RETRY_CNT_EN
    // Count failed write attempts, saturating at 255
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_cnt <= 8'd0;
        end else if (state == CHECK && !write_ok && retry_cnt != 8'hFF) begin
            retry_cnt <= retry_cnt + 8'd1;
        end
    end
`else
    assign retry_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [DW-1:0]   pdata [N];
    logic [N*DW-1:0] req_data;
    logic            fifo_full = 1'b0;
    logic            fifo_wr_ack = 1'b0;
    logic            fifo_overflow = 1'b0;
    logic            nack = 1'b0;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data_in;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [7:0]      retry_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .fifo_full(fifo_full), .fifo_wr_ack(fifo_wr_ack), .fifo_overflow(fifo_overflow),
        .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in), .gnt(gnt),
        .busy(busy), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    assign req_data = {pdata[3], pdata[2], pdata[1], pdata[0]};

    // FIFO stand-in: registered ack when a write lands while not full and not forced to reject
    always @(posedge clk) begin
        fifo_wr_ack   <= fifo_wr_en && !fifo_full && !nack;
        fifo_overflow <= fifo_wr_en && (fifo_full || nack);
    end

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic          full;
        logic          nack;
        logic          exp_wr_en;
        logic [DW-1:0] exp_data;
        logic [N-1:0]  exp_gnt;
        logic          exp_busy;
    } vec_t;

    vec_t          vecs [$];
    logic [DW-1:0] dval [N];
    logic [DW-1:0] tab_data = '0;
    int            exp_retry;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic r, input logic [N-1:0] rq, input logic f, input logic nk,
                           input logic we, input int win, input logic [N-1:0] g, input logic b);
        vec_t v;
        if (r) tab_data = '0;
        else if (we) tab_data = dval[win];
        v.rst = r; v.req = rq; v.full = f; v.nack = nk;
        v.exp_wr_en = we; v.exp_data = tab_data; v.exp_gnt = g; v.exp_busy = b;
        vecs.push_back(v);
    endtask

    // Random-phase reference model state
    int            last, pend, busy_left, nacks, win;
    logic          ack_seen, exp_issue, found;
    logic [N-1:0]  prev_gnt, elig, exp_g, drop_lag;
    logic [DW-1:0] cur_data;

    initial begin
        dval[0] = 16'h1111; dval[1] = 16'h2222; dval[2] = 16'hA5A5; dval[3] = 16'h4444;
        for (int i = 0; i < N; i++) pdata[i] = dval[i];

        // Reset with every producer requesting
        #2 rst = 1'b1; req = 4'hF;
        #1;
        chk("rst0 wr_en", fifo_wr_en, 0); chk("rst0 gnt", gnt, 0);
        chk("rst0 busy", busy, 0);        chk("rst0 retry", retry_cnt, 0);
        chk("rst0 data", fifo_data_in, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst wr_en", fifo_wr_en, 0); chk("rst gnt", gnt, 0);
            chk("rst busy", busy, 0);        chk("rst retry", retry_cnt, 0);
        end
        rst = 1'b0; req = '0;
        step();

        // Single request, late drop after gnt must not be re-granted
        add_vec(0, 4'b0100, 0, 0, 1, 2, 4'b0000, 1);
        add_vec(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 1);
        add_vec(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 0);
        add_vec(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 0);
        add_vec(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        // Round-robin rotation with all producers requesting
        add_vec(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        add_vec(0, 4'b1111, 0, 0, 1, 0, 4'b0000, 1);
        add_vec(0, 4'b1111, 0, 0, 0, 0, 4'b0000, 1);
        add_vec(0, 4'b1111, 0, 0, 0, 0, 4'b0001, 0);
        add_vec(0, 4'b1111, 0, 0, 1, 1, 4'b0000, 1);
        add_vec(0, 4'b1110, 0, 0, 0, 0, 4'b0000, 1);
        add_vec(0, 4'b1111, 0, 0, 0, 0, 4'b0010, 0);
        add_vec(0, 4'b1111, 0, 0, 1, 2, 4'b0000, 1);
        add_vec(0, 4'b1101, 0, 0, 0, 0, 4'b0000, 1);
        add_vec(0, 4'b1111, 0, 0, 0, 0, 4'b0100, 0);
        add_vec(0, 4'b1111, 0, 0, 1, 3, 4'b0000, 1);
        add_vec(0, 4'b1011, 0, 0, 0, 0, 4'b0000, 1);
        add_vec(0, 4'b1111, 0, 0, 0, 0, 4'b1000, 0);
        add_vec(0, 4'b1111, 0, 0, 1, 0, 4'b0000, 1);
        add_vec(0, 4'b0111, 0, 0, 0, 0, 4'b0000, 1);
        add_vec(0, 4'b1111, 0, 0, 0, 0, 4'b0001, 0);
        add_vec(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        // FIFO full blocks issue; release issues next cycle
        for (int c = 0; c < 10; c++) add_vec(0, 4'b0001, 1, 0, 0, 0, 4'b0000, 0);
        add_vec(0, 4'b0001, 0, 0, 1, 0, 4'b0000, 1);
        add_vec(0, 4'b0001, 0, 0, 0, 0, 4'b0000, 1);
        add_vec(0, 4'b0001, 0, 0, 0, 0, 4'b0001, 0);
        add_vec(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);
        // Full rising during ISSUE: write still checked, no ack, same producer retries
        add_vec(0, 4'b0100, 0, 0, 1, 2, 4'b0000, 1);
        add_vec(0, 4'b0100, 1, 0, 0, 0, 4'b0000, 1);
        add_vec(0, 4'b0100, 1, 0, 0, 0, 4'b0000, 0);
        add_vec(0, 4'b0100, 0, 0, 1, 2, 4'b0000, 1);
        add_vec(0, 4'b0100, 0, 0, 0, 0, 4'b0000, 1);
        add_vec(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 0);
        add_vec(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req = vecs[i].req; fifo_full = vecs[i].full; nack = vecs[i].nack;
            step();
            chk($sformatf("v%0d wr_en", i), fifo_wr_en, vecs[i].exp_wr_en);
            chk($sformatf("v%0d data", i), fifo_data_in, vecs[i].exp_data);
            chk($sformatf("v%0d gnt", i), gnt, vecs[i].exp_gnt);
            chk($sformatf("v%0d busy", i), busy, vecs[i].exp_busy);
        end
        rst = 1'b0; fifo_full = 1'b0; nack = 1'b0;

        // Reset in ISSUE abandons the write and restarts the search at producer 0
        req = 4'b0010; step();
        chk("r34 pre wr_en", fifo_wr_en, 1); chk("r34 pre data", fifo_data_in, dval[1]);
        step(); step();
        chk("r34 pre gnt", gnt, 4'b0010);
        req = 4'b0000; step();
        req = 4'b0100; step();
        chk("r34 issue", fifo_wr_en, 1);
        #3 rst = 1'b1;
        #1;
        chk("r34 async wr_en", fifo_wr_en, 0); chk("r34 async busy", busy, 0);
        chk("r34 async data", fifo_data_in, 0);
        step(); chk("r34 gnt a", gnt, 0); chk("r34 wr_en a", fifo_wr_en, 0);
        step(); chk("r34 gnt b", gnt, 0);
        rst = 1'b0; req = 4'b0110; step();
        chk("r34 re wr_en", fifo_wr_en, 1); chk("r34 re data", fifo_data_in, dval[1]);
        step(); step();
        chk("r34 re gnt", gnt, 4'b0010);
        req = 4'b0000; step();

        // Unacknowledged first attempt, acked retry
`ifdef FIFO_ARB_RETRY_CNT_EN
        exp_retry = 1;
`else
        exp_retry = 0;
`endif
        rst = 1'b1; step(); rst = 1'b0; step();
        req = 4'b0010; nack = 1'b1; step();
        chk("r33 wr_en1", fifo_wr_en, 1);
        step(); nack = 1'b0;
        chk("r33 busy", busy, 1);
        step();
        chk("r33 no gnt", gnt, 0); chk("r33 retry", retry_cnt, exp_retry);
        step();
        chk("r33 wr_en2", fifo_wr_en, 1); chk("r33 data2", fifo_data_in, dval[1]);
        step(); step();
        chk("r33 gnt", gnt, 4'b0010); chk("r33 retry hold", retry_cnt, exp_retry);
        req = 4'b0000; step();

        // Randomized traffic against a transaction-level model
        rst = 1'b1; step(); rst = 1'b0; step();
        last = N - 1; busy_left = 0; nacks = 0; pend = 0; ack_seen = 1'b0;
        prev_gnt = '0; drop_lag = '0; cur_data = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            elig = req & ~prev_gnt;
            exp_issue = (busy_left == 0) && (elig != 0) && !fifo_full;
            exp_g = '0;
            if (exp_issue) begin
                found = 1'b0; win = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!found && elig[(last + k) % N]) begin
                        found = 1'b1; win = (last + k) % N;
                    end
                end
                cur_data = pdata[win]; pend = win; busy_left = 2;
            end else if (busy_left == 2) begin
                busy_left = 1; ack_seen = fifo_wr_ack;
            end else if (busy_left == 1) begin
                busy_left = 0;
                if (ack_seen) begin
                    exp_g = N'(1 << pend); last = pend;
                end else begin
                    nacks++;
                end
            end
            chk("rnd wr_en", fifo_wr_en, exp_issue);
            chk("rnd data", fifo_data_in, cur_data);
            chk("rnd gnt", gnt, exp_g);
            chk("rnd busy", busy, busy_left != 0);
            prev_gnt = exp_g;
            for (int i = 0; i < N; i++) begin
                if (drop_lag[i]) begin
                    req[i] = 1'b0; drop_lag[i] = 1'b0;
                end else if (exp_g[i]) begin
                    if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                    else drop_lag[i] = 1'b1;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    pdata[i] = 16'($urandom);
                    req[i] = 1'b1;
                end
            end
            fifo_full = ($urandom_range(0, 4) == 0);
            nack      = ($urandom_range(0, 4) == 0);
        end
`ifdef FIFO_ARB_RETRY_CNT_EN
        exp_retry = (nacks > 255) ? 255 : nacks;
`else
        exp_retry = 0;
`endif
        chk("rnd retry", retry_cnt, exp_retry);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
